// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter slice.
//   arb_state_t       : arbiter FSM state encoding
//   N_REQ_DEF         : default number of byte producers
//   BUSY_TIMEOUT_DEF  : default cycles allowed for uart_tx busy to rise
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_t;

   localparam int N_REQ_DEF        = 4;
   localparam int BUSY_TIMEOUT_DEF = 4;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin winner selection.
// Ports:
//   req        in  N_REQ   request vector
//   last_grant in  IDX_W   index granted most recently
//   any_req    out 1       at least one request present
//   win        out IDX_W   first requester found searching from last_grant+1
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last_grant,
   output logic             any_req,
   output logic [IDX_W-1:0] win
);

   logic             found;
   logic [IDX_W-1:0] idx;

   assign any_req = |req;

   // Walk offsets 1..N_REQ so the previous winner is checked last.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = IDX_W'((int'(last_grant) + k) % N_REQ);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin scheduler sharing one uart_tx byte transmitter among N_REQ
// producers. Accepts one byte at a time, issues a single-cycle start and
// tracks the transmitter's busy through the whole frame before granting again.
// Ports:
//   clk         in  1          system clock, rising edge
//   rst_n       in  1          asynchronous active-low reset
//   req_valid   in  N_REQ      requester i has a byte on req_data[i]
//   req_data    in  N_REQ x 8  byte per requester
//   req_ready   out N_REQ      one-hot single-cycle accept pulse
//   tx_start    out 1          single-cycle start pulse to uart_tx
//   tx_data     out 8          byte to uart_tx, held until the next accept
//   tx_busy     in  1          uart_tx busy
//   grant_id    out IDX_W      requester currently being served
//   active      out 1          high from accept until the frame completes
//   timeout_err out 1          sticky: busy failed to rise after tx_start
//   err_clr     in  1          clears timeout_err (a new timeout wins)
// -----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ        = N_REQ_DEF,
   parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ-1:0][7:0]      req_data,
   output logic [N_REQ-1:0]           req_ready,
   output logic                       tx_start,
   output logic [7:0]                 tx_data,
   input  logic                       tx_busy,
   output logic [$clog2(N_REQ)-1:0]   grant_id,
   output logic                       active,
   output logic                       timeout_err,
   input  logic                       err_clr
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

   arb_state_t       state;
   logic [IDX_W-1:0] last_grant;
   logic [CNT_W-1:0] cnt;
   logic             any_req;
   logic [IDX_W-1:0] win;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req        (req_valid),
      .last_grant (last_grant),
      .any_req    (any_req),
      .win        (win)
   );

   // All outputs are registered: the decision taken in a state shows up on
   // the outputs one cycle later. Hence the accept pulse is visible while the
   // FSM sits in ISSUE, and tx_start is visible during the first WAIT_BUSY
   // cycle, giving accept-to-start of exactly one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         req_ready   <= '0;
         tx_start    <= 1'b0;
         tx_data     <= '0;
         grant_id    <= '0;
         active      <= 1'b0;
         timeout_err <= 1'b0;
         last_grant  <= IDX_W'(N_REQ - 1);
         cnt         <= '0;
      end else begin
         req_ready <= '0;
         tx_start  <= 1'b0;

         // A timeout set further down overrides this clear.
         if (err_clr) begin
            timeout_err <= 1'b0;
         end

         case (state)
            IDLE: begin
               // Busy high here means the transmitter is in use by someone
               // else (or a frame survived our reset): hold off.
               if (any_req && !tx_busy) begin
                  req_ready  <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
                  tx_data    <= req_data[win];
                  grant_id   <= win;
                  last_grant <= win;
                  active     <= 1'b1;
                  state      <= ISSUE;
               end
            end

            ISSUE: begin
               tx_start <= 1'b1;
               cnt      <= CNT_W'(BUSY_TIMEOUT);
               state    <= WAIT_BUSY;
            end

            WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= WAIT_DONE;
               end else if (cnt <= CNT_W'(1)) begin
                  // Last allowed cycle expired without busy.
                  cnt         <= '0;
                  timeout_err <= 1'b1;
                  active      <= 1'b0;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            WAIT_DONE: begin
               if (!tx_busy) begin
                  active <= 1'b0;
                  state  <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `uart_tx` byte transmitter among `N_REQ` byte producers. It accepts a byte from one requester at a time over a valid/ready handshake and issues a single-cycle `start` with the byte to the transmitter. It then tracks the transmitter's `busy` through a full frame before granting again. It sits between the producer blocks (command/status/debug streams) and the `uart_tx` instance.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `BUSY_TIMEOUT`, 4: cycles allowed for `tx_busy` to rise after `tx_start`.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  requester i has a byte on `req_data[i]`.
- `req_data`  in  N_REQ x 8  byte per requester.
- `req_ready`  out  N_REQ  one-hot, single-cycle accept pulse.
- `tx_start`  out  1  single-cycle start pulse to `uart_tx`.
- `tx_data`  out  8  byte to `uart_tx` `data_in`, valid with `tx_start`.
- `tx_busy`  in  1  `uart_tx` `busy`.
- `grant_id`  out  $clog2(N_REQ)  index of the requester currently being served.
- `active`  out  1  high from accept until the frame completes.
- `timeout_err`  out  1  sticky; set when `tx_busy` fails to rise in time.
- `err_clr`  in  1  clears `timeout_err`.

## Operation
- State machine `IDLE`, `ISSUE`, `WAIT_BUSY`, `WAIT_DONE`.
- **IDLE**
  - If any `req_valid` and `tx_busy`=0, pick a winner round-robin.
  - Search starts at `last_grant+1` and wraps modulo N_REQ.
  - Pulse `req_ready[w]`, latch `req_data[w]` into `tx_data`, set `grant_id`=w, `last_grant`=w, `active`=1.
  - Go to `ISSUE`.
- **ISSUE**: `tx_start`=1 for exactly this cycle. Load the timeout counter with `BUSY_TIMEOUT`. Go to `WAIT_BUSY`.
- **WAIT_BUSY**
  - On `tx_busy`=1, go to `WAIT_DONE`.
  - Otherwise decrement the counter. At 0, set `timeout_err`, clear `active`, and go to `IDLE`.
- **WAIT_DONE**: on `tx_busy`=0, clear `active` and go to `IDLE`.
- While `tx_busy`=1 in `IDLE` (external/unexpected use), no grant is issued.
- A requester may drop `req_valid` at any time before its `req_ready` pulse without penalty.
- `tx_data` holds its value until the next accept.
- `timeout_err`
  - Set has priority over `err_clr` in the same cycle.
  - `err_clr` has no other effect.

## Timing
- Reset values
  - `req_ready`=0, `tx_start`=0, `tx_data`=0, `grant_id`=0, `active`=0, `timeout_err`=0, state `IDLE`.
  - `last_grant`=N_REQ-1, so requester 0 is first priority after reset.
- Accept to `tx_start`: 1 cycle. `req_ready` in cycle T, `tx_start` in T+1.
- `uart_tx` raises `busy` at T+2. The frame (start, 8 data, parity, stop) drops `busy` about 11 cycles later.
- Back-to-back throughput: the next `req_ready` comes no earlier than the cycle after `tx_busy` is sampled low in `WAIT_DONE`.
- Simultaneous requests: exactly one `req_ready` per frame. Each active requester is served within N_REQ frames (no starvation).
- Reset mid-operation
  - All outputs return immediately to reset values.
  - An in-flight `uart_tx` frame is not tracked further.
  - After reset release, the arbiter waits in `IDLE` for `tx_busy`=0.

## Structure
- Shared package `uart_pkg` holds `arb_state_t` (logic [1:0] enum) and the default `N_REQ`/`BUSY_TIMEOUT` constants.
- Sub-module `rr_arbiter`
  - Purely combinational.
  - Inputs: `req` vector and `last_grant`.
  - Outputs: `any_req`, winner index `win`.
  - `uart_tx_arbiter` owns the FSM, pointer, data latch and timeout counter.

## Test plan
- Single request: `req_valid`=0001, `req_data[0]`=8'hA5.
  - Expect `req_ready[0]` at T, `tx_start` at T+1 with `tx_data`=8'hA5.
  - Expect `active` high until `tx_busy` falls.
  - With `uart_tx` attached, the line carries A5 LSB first, then parity bit 0.
- All four valid continuously with bytes 10/21/32/43: transmitted order is 10,21,32,43,10 (round-robin from 0 after reset).
- `last_grant`=2, requests 0 and 3 valid: requester 3 is granted first, then 0.
- `tx_busy` tied low: after `tx_start`, `timeout_err`=1 exactly BUSY_TIMEOUT cycles later and the FSM is back in `IDLE`. `err_clr` then clears it. `err_clr` in the same cycle as a new timeout leaves it set.
- `rst_n` low during `WAIT_DONE`:
  - Outputs go to reset values asynchronously.
  - No `req_ready` while `tx_busy` is still high after release.
  - Requester 0 is granted first once busy falls.
